// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing Diff = A - B - Bin, one bit per clock, LSB first.
// Exposes per-bit propagate (A^B) and borrow chain; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             overflow,
  output logic [WIDTH-1:0] AxorB_out,
  output logic [WIDTH-1:0] Bin_out
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_r, b_r;
  logic            br;
  logic [IW-1:0]   idx;

  logic accept, last;
  logic a_bit, b_bit, p_bit, d_bit, bnext;

  always_comb begin
    accept = start && (state != SHIFT);
    last   = (idx == IW'(WIDTH - 1));
    a_bit  = a_r[idx];
    b_bit  = b_r[idx];
    p_bit  = a_bit ^ b_bit;
    d_bit  = p_bit ^ br;
    bnext  = (~a_bit & b_bit) | (~p_bit & br);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      br        <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
      overflow  <= 1'b0;
      AxorB_out <= '0;
      Bin_out   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_r       <= A;
        b_r       <= B;
        br        <= Bin;
        idx       <= '0;
        busy      <= 1'b1;
        Diff      <= '0;
        Bout      <= 1'b0;
        overflow  <= 1'b0;
        AxorB_out <= '0;
        Bin_out   <= '0;
      end else if (state == SHIFT) begin
        Diff[idx]      <= d_bit;
        AxorB_out[idx] <= p_bit;
        Bin_out[idx]   <= bnext;
        br             <= bnext;
        if (last) begin
          // overflow uses the MSB difference bit resolved on this same edge
          Bout     <= bnext;
          overflow <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ d_bit);
          busy     <= 1'b0;
          done     <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor: table of hand-computed results plus
// handshake, back-to-back and mid-operation reset sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Bin = 1'b0;
  logic         busy, done, Bout, overflow;
  logic [W-1:0] Diff, AxorB_out, Bin_out;

  int n_vec  = 0;
  int n_miss = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .overflow(overflow),
    .AxorB_out(AxorB_out), .Bin_out(Bin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout, ovf;
    logic [W-1:0] axb, bo;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts an operation at the next rising edge and waits (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int cycles;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    check("accept_diff_clr", 32'(Diff), 32'd0);
    check("accept_bo_clr", 32'(Bin_out), 32'd0);
    cycles = 0;
    while (!done && cycles < 3 * W) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", 32'(cycles), 32'(W));
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    //        a      b      bin   diff   bout  ovf   axb    bo
    vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 8'h06, 8'h02};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h01, 8'hFF};
    vt[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8'h81, 8'h7F};
    vt[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 8'h80, 8'h80};
    vt[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 8'h1F, 8'h0F};
    vt[5] = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 8'h0D, 8'h04};
    vt[6] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 8'hFE, 8'h00};
    vt[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'hFF};
    vt[8] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 8'h80, 8'h7F};
    vt[9] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 8'hFF, 8'h55};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(Diff), 32'd0);
    check("rst_bout", 32'(Bout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_axb", 32'(AxorB_out), 32'd0);
    check("rst_bo", 32'(Bin_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Table: even entries start from IDLE, odd entries start in the DONE cycle
    foreach (vt[i]) begin
      if (i % 2 == 0) begin
        repeat (2) @(posedge clk);
        #1;
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
      end
      run_op(vt[i].a, vt[i].b, vt[i].bin);
      check($sformatf("v%0d_diff", i), 32'(Diff), 32'(vt[i].diff));
      check($sformatf("v%0d_bout", i), 32'(Bout), 32'(vt[i].bout));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vt[i].ovf));
      check($sformatf("v%0d_axb", i), 32'(AxorB_out), 32'(vt[i].axb));
      check($sformatf("v%0d_bo", i), 32'(Bin_out), 32'(vt[i].bo));
    end

    // start held high with changing operands while busy must be ignored
    repeat (3) @(posedge clk);
    @(negedge clk);
    A = 8'h05; B = 8'h03; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
      @(posedge clk);
    end
    #1;
    check("hold_done", 32'(done), 32'd1);
    check("hold_diff", 32'(Diff), 32'h02);
    check("hold_bo", 32'(Bin_out), 32'h02);
    check("hold_axb", 32'(AxorB_out), 32'h06);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("hold_done_pulse", 32'(done), 32'd0);
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_diff_kept", 32'(Diff), 32'h02);

    // Back-to-back: second start lands in the DONE cycle
    run_op(8'h05, 8'h03, 1'b0);
    check("b2b_first", 32'(Diff), 32'h02);
    run_op(8'h09, 8'h04, 1'b0);
    check("b2b_second", 32'(Diff), 32'h05);

    // Reset after 4 bits of FF-01 resolved
    repeat (2) @(posedge clk);
    @(negedge clk);
    A = 8'hFF; B = 8'h01; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_partial_diff", 32'(Diff), 32'h0E);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_diff", 32'(Diff), 32'd0);
    check("mid_rst_axb", 32'(AxorB_out), 32'd0);
    check("mid_rst_bo", 32'(Bin_out), 32'd0);
    check("mid_rst_bout", 32'(Bout) | 32'(overflow) | 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 2 * W; i++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      check("mid_no_done", 32'(seen), 32'd0);
    end
    run_op(8'hFF, 8'h01, 1'b0);
    check("post_rst_diff", 32'(Diff), 32'hFE);
    check("post_rst_axb", 32'(AxorB_out), 32'hFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
